ahb_sram_slave: RTL and testbench

- AHB slave that sits directly downstream of the team's AHB master and consumes its address/control/data phases.
- Backs a word-organised on-chip SRAM (flop array) with a configurable number of wait states.
- Signals ERROR with the two-cycle protocol for illegal accesses.
- Bus-level HREADY is fed back from the interconnect; HREADYOUT is this slave's contribution.

---
 rtl/ahb_pkg.sv | 29 ++
 rtl/ahb_byte_lanes.sv | 20 ++
 rtl/ahb_sram_slave.sv | 112 +++++++++++
 tb/tb_ahb_sram_slave.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave state type.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    OKAY  = 2'b00,
    ERROR = 2'b01,
    RETRY = 2'b10,
    SPLIT = 2'b11
  } hresp_t;

  localparam logic [2:0] SZ_BYTE = 3'b000;
  localparam logic [2:0] SZ_HALF = 3'b001;
  localparam logic [2:0] SZ_WORD = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_ERR1,
    S_ERR2
  } slave_state_t;

endpackage

// File: rtl/ahb_byte_lanes.sv
// Little-endian byte-enable decode from transfer size and low address bits.
module ahb_byte_lanes
  import ahb_pkg::*;
(
  input  logic [2:0] i_size,
  input  logic [1:0] i_addr,
  output logic [3:0] o_be
);

  always_comb begin
    o_be = '0;
    case (i_size)
      SZ_BYTE: o_be = 4'b0001 << i_addr;
      SZ_HALF: o_be = i_addr[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: o_be = '1;
      default: o_be = '0;
    endcase
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave backed by a word-organised flop SRAM with fixed wait states
// and the two-cycle ERROR response for illegal accesses.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int          MEM_WORDS   = 256,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ADDR_MASK   = 32'h0000_FFFF
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic [1:0]  HRESP
);

  localparam int          AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);
  localparam logic [3:0]  WS        = 4'(WAIT_STATES);

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_ws_check
    $error("ahb_sram_slave: WAIT_STATES must be in 0..15");
  end

  slave_state_t r_state, w_state_n;
  logic [3:0]   r_wcnt, w_wcnt_n;
  logic [31:0]  r_addr;
  logic         r_write;
  logic [2:0]   r_size;
  logic [31:0]  r_mem [MEM_WORDS];

  logic [31:0]   w_off;
  logic          w_illegal;
  logic          w_done;
  logic          w_open;
  logic          w_take;
  logic [3:0]    w_be;
  logic [AW-1:0] w_word;
  logic          w_unused;

  assign w_off     = HADDR & ADDR_MASK;
  assign w_illegal = (HSIZE > SZ_WORD)
                   | ((HSIZE == SZ_HALF) & HADDR[0])
                   | ((HSIZE == SZ_WORD) & (|HADDR[1:0]))
                   | (w_off >= MEM_BYTES);
  assign w_done    = (r_state == S_DATA) && (r_wcnt == '0);
  // New address phases are taken wherever this slave drives HREADYOUT high.
  assign w_open    = (r_state == S_IDLE) || (r_state == S_ERR2) || w_done;
  assign w_take    = w_open & HSEL & HREADY & HTRANS[1];
  assign w_word    = r_addr[AW+1:2];
  assign w_unused  = ^{HBURST, HTRANS[0], r_addr[31:AW+2]};

  ahb_byte_lanes u_lanes (
    .i_size (r_size),
    .i_addr (r_addr[1:0]),
    .o_be   (w_be)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_size  <= '0;
    end else begin
      r_state <= w_state_n;
      r_wcnt  <= w_wcnt_n;
      if (w_take) begin
        r_addr  <= w_off;
        r_write <= HWRITE;
        r_size  <= HSIZE;
      end
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_wcnt_n  = r_wcnt;
    case (r_state)
      S_DATA:  if (r_wcnt != '0) w_wcnt_n = r_wcnt - 4'd1;
      S_ERR1:  w_state_n = S_ERR2;
      default: ;
    endcase
    if (w_open) begin
      w_state_n = w_take ? (w_illegal ? S_ERR1 : S_DATA) : S_IDLE;
      w_wcnt_n  = WS;
    end
  end

  // SRAM contents survive reset; the state reset alone blocks a pending commit.
  always_ff @(posedge HCLK) begin
    if (w_done && r_write) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_word][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  assign HREADYOUT = !((r_state == S_ERR1) || ((r_state == S_DATA) && (r_wcnt != '0)));
  assign HRESP     = ((r_state == S_ERR1) || (r_state == S_ERR2)) ? ERROR : OKAY;
  assign HRDATA    = ((r_state == S_DATA) && !r_write) ? r_mem[w_word] : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Randomised and directed bench for ahb_sram_slave at WAIT_STATES 0 and 2,
// checked every cycle against a transaction-queue model of the slave.
module tb_ahb_sram_slave;

  logic HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int n_cmp  = 0;
  int n_fail = 0;
  bit env_done [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One expected data-phase cycle; commit marks the edge a write lands.
  typedef struct packed {
    logic        rdy;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic        commit;
    logic [7:0]  widx;
    logic [3:0]  be;
  } exp_t;

  for (genvar g = 0; g < 2; g++) begin : g_env
    localparam int WS = 2 * g;

    logic        rstn;
    logic        HSEL, HWRITE, HREADY, HREADYOUT, ext_stall;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS, HRESP;
    logic [2:0]  HSIZE, HBURST;

    assign HREADY = HREADYOUT & ~ext_stall;

    ahb_sram_slave #(
      .MEM_WORDS   (256),
      .WAIT_STATES (WS),
      .ADDR_MASK   (32'h0000_FFFF)
    ) u_dut (
      .HCLK      (HCLK),
      .HRESETn   (rstn),
      .HSEL      (HSEL),
      .HADDR     (HADDR),
      .HTRANS    (HTRANS),
      .HWRITE    (HWRITE),
      .HSIZE     (HSIZE),
      .HBURST    (HBURST),
      .HWDATA    (HWDATA),
      .HREADY    (HREADY),
      .HREADYOUT (HREADYOUT),
      .HRDATA    (HRDATA),
      .HRESP     (HRESP)
    );

    exp_t        q[$];
    logic [31:0] mmem [256];

    always @(posedge HCLK or negedge rstn) begin : p_model
      logic        rdy, bad;
      logic [31:0] off;
      exp_t        e;
      if (!rstn) begin
        q.delete();
      end else begin
        rdy = (q.size() == 0) ? 1'b1 : q[0].rdy;
        if (q.size() != 0) begin
          if (q[0].commit)
            for (int b = 0; b < 4; b++)
              if (q[0].be[b]) mmem[q[0].widx][8*b +: 8] = HWDATA[8*b +: 8];
          void'(q.pop_front());
        end
        if (rdy && !ext_stall && HSEL && HTRANS[1]) begin
          off = HADDR & 32'h0000_FFFF;
          bad = (HSIZE > 3'd2) || (HSIZE == 3'd1 && HADDR[0]) ||
                (HSIZE == 3'd2 && HADDR[1:0] != 2'b00) || (off >= 32'd1024);
          if (bad) begin
            e = '0; e.resp = 2'b01; e.rdy = 1'b0; q.push_back(e);
            e.rdy = 1'b1; q.push_back(e);
          end else begin
            for (int i = 0; i <= WS; i++) begin
              e        = '0;
              e.rdy    = (i == WS);
              e.widx   = off[9:2];
              e.be     = (HSIZE == 3'd0) ? (4'b0001 << off[1:0]) :
                         (HSIZE == 3'd1) ? (off[1] ? 4'hC : 4'h3) : 4'hF;
              e.commit = HWRITE && (i == WS);
              e.rdata  = HWRITE ? 32'h0 : mmem[off[9:2]];
              q.push_back(e);
            end
          end
        end
      end
    end

    always @(negedge HCLK) begin : p_compare
      exp_t e;
      if (q.size() == 0) begin e = '0; e.rdy = 1'b1; end
      else e = q[0];
      n_cmp++;
      if (HREADYOUT !== e.rdy || HRESP !== e.resp || HRDATA !== e.rdata) begin
        n_fail++;
        $display("FAIL ws%0d_cycle t=%0t: rdy/resp/rdata got %b/%h/%h expected %b/%h/%h",
                 WS, $time, HREADYOUT, HRESP, HRDATA, e.rdy, e.resp, e.rdata);
      end
    end

    logic        dp_active;
    logic [31:0] dp_wdata;
    int          dp_lows;
    logic [31:0] last_rdata;
    logic [1:0]  last_resp;
    int          last_lows, last_tries;

    task automatic step(input logic sel, input logic [1:0] trans, input logic wr,
                        input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic stall, output logic taken);
      @(negedge HCLK);
      HSEL = sel; HTRANS = trans; HWRITE = wr; HSIZE = size; HADDR = addr;
      HBURST = 3'($urandom_range(7)); HWDATA = dp_wdata;
      ext_stall = stall && !dp_active;
      #4;
      taken = HREADY && sel && trans[1];
      if (dp_active) begin
        if (HREADY) begin
          last_rdata = HRDATA; last_resp = HRESP; last_lows = dp_lows; dp_active = 1'b0;
        end else if (!HREADYOUT) dp_lows++;
      end
      if (taken) begin dp_active = 1'b1; dp_lows = 0; dp_wdata = wdata; end
    endtask

    task automatic issue(input logic [1:0] trans, input logic wr, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic stall_en);
      logic t = 1'b0;
      int   n = 0;
      while (!t && n < 64) begin
        step(1'b1, trans, wr, size, addr, wdata, stall_en && ($urandom_range(3) == 0), t);
        n++;
      end
      last_tries = n;
      chk($sformatf("ws%0d_accept", WS), 32'(t), 32'd1);
    endtask

    task automatic flush();
      logic t;
      int   n = 0;
      while (dp_active && n < 64) begin
        step(1'b0, 2'b00, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, t);
        n++;
      end
      chk($sformatf("ws%0d_flush", WS), 32'(dp_active), 32'd0);
    endtask

    initial begin : p_stim
      logic        t;
      logic [2:0]  sz;
      logic [31:0] off, addr;
      int          k;
      rstn = 1'b0; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd0;
      HADDR = '0; HBURST = '0; HWDATA = '0; ext_stall = 1'b0;
      dp_active = 1'b0; dp_wdata = '0; dp_lows = 0;
      last_rdata = '0; last_resp = '0; last_lows = 0; last_tries = 0;
      #1;
      chk($sformatf("ws%0d_rst_rdy", WS),   32'(HREADYOUT), 32'd1);
      chk($sformatf("ws%0d_rst_resp", WS),  32'(HRESP), 32'd0);
      chk($sformatf("ws%0d_rst_rdata", WS), HRDATA, 32'h0);
      repeat (3) @(negedge HCLK);
      rstn = 1'b1;

      for (int i = 0; i < 256; i++) issue(2'b10, 1'b1, 3'd2, 32'(i * 4), {16'hC0DE, 16'(i)}, 1'b0);
      flush();

      // pipelined write then read of the same word
      issue(2'b10, 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 1'b0);
      issue(2'b10, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0);
      chk($sformatf("ws%0d_t1_rd_tries", WS), 32'(last_tries), 32'(WS + 1));
      chk($sformatf("ws%0d_t1_wr_lows", WS),  32'(last_lows), 32'(WS));
      flush();
      chk($sformatf("ws%0d_t1_rdata", WS), last_rdata, 32'hDEAD_BEEF);
      chk($sformatf("ws%0d_t1_resp", WS),  32'(last_resp), 32'd0);
      chk($sformatf("ws%0d_t1_rd_lows", WS), 32'(last_lows), 32'(WS));

      // back-to-back reads: second address phase held until the first completes
      issue(2'b10, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0);
      issue(2'b10, 1'b0, 3'd2, 32'h0, 32'h0, 1'b0);
      chk($sformatf("ws%0d_t2_tries", WS), 32'(last_tries), 32'(WS + 1));
      chk($sformatf("ws%0d_t2_rdata0", WS), last_rdata, 32'hDEAD_BEEF);
      flush();
      chk($sformatf("ws%0d_t2_rdata1", WS), last_rdata, 32'hC0DE_0000);
      chk($sformatf("ws%0d_t2_lows", WS), 32'(last_lows), 32'(WS));

      // byte/half merge
      issue(2'b10, 1'b1, 3'd0, 32'h20, 32'h0000_0011, 1'b0);
      issue(2'b10, 1'b1, 3'd0, 32'h21, 32'h0000_2200, 1'b0);
      issue(2'b10, 1'b1, 3'd1, 32'h22, 32'h4433_0000, 1'b0);
      issue(2'b10, 1'b0, 3'd2, 32'h20, 32'h0, 1'b0);
      flush();
      chk($sformatf("ws%0d_t3_merge", WS), last_rdata, 32'h4433_2211);

      // illegal accesses
      issue(2'b10, 1'b1, 3'd2, 32'h2, 32'hBAD0_BAD0, 1'b0);
      flush();
      chk($sformatf("ws%0d_t4_mis_resp", WS), 32'(last_resp), 32'd1);
      chk($sformatf("ws%0d_t4_mis_lows", WS), 32'(last_lows), 32'd1);
      issue(2'b10, 1'b0, 3'd2, 32'h400, 32'h0, 1'b0);
      flush();
      chk($sformatf("ws%0d_t4_oob_resp", WS), 32'(last_resp), 32'd1);
      chk($sformatf("ws%0d_t4_oob_rdata", WS), last_rdata, 32'h0);
      issue(2'b10, 1'b0, 3'd2, 32'h0, 32'h0, 1'b0);
      flush();
      chk($sformatf("ws%0d_t4_unchanged", WS), last_rdata, 32'hC0DE_0000);

      // INCR4 write with a BUSY beat, then read back
      issue(2'b10, 1'b1, 3'd2, 32'h30, 32'h5000_0030, 1'b0);
      issue(2'b11, 1'b1, 3'd2, 32'h34, 32'h5000_0034, 1'b0);
      k = 0;
      while (dp_active && k < 64) begin step(1'b1, 2'b01, 1'b1, 3'd2, 32'h38, 32'h0, 1'b0, t); k++; end
      step(1'b1, 2'b01, 1'b1, 3'd2, 32'h38, 32'h0, 1'b0, t);
      chk($sformatf("ws%0d_t5_busy_rdy", WS),  32'(HREADYOUT), 32'd1);
      chk($sformatf("ws%0d_t5_busy_resp", WS), 32'(HRESP), 32'd0);
      issue(2'b11, 1'b1, 3'd2, 32'h38, 32'h5000_0038, 1'b0);
      issue(2'b11, 1'b1, 3'd2, 32'h3C, 32'h5000_003C, 1'b0);
      flush();
      for (int b = 0; b < 4; b++) begin
        issue(b == 0 ? 2'b10 : 2'b11, 1'b0, 3'd2, 32'h30 + 32'(4 * b), 32'h0, 1'b0);
        flush();
        chk($sformatf("ws%0d_t5_beat%0d", WS, b), last_rdata, 32'h5000_0030 + 32'(4 * b));
      end

      // reset in the middle of a write's data phase
      issue(2'b10, 1'b1, 3'd2, 32'h40, 32'h1234_5678, 1'b0);
      flush();
      issue(2'b10, 1'b1, 3'd2, 32'h40, 32'hCAFE_F00D, 1'b0);
      k = (WS >= 2) ? 1 : 0;
      repeat (k) step(1'b0, 2'b00, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, t);
      @(negedge HCLK);
      HSEL = 1'b0; HTRANS = 2'b00; HWDATA = dp_wdata;
      #2;
      chk($sformatf("ws%0d_t6_pre_rdy", WS), 32'(HREADYOUT), 32'(WS == 0));
      rstn = 1'b0;
      #1;
      chk($sformatf("ws%0d_t6_rst_rdy", WS),   32'(HREADYOUT), 32'd1);
      chk($sformatf("ws%0d_t6_rst_resp", WS),  32'(HRESP), 32'd0);
      chk($sformatf("ws%0d_t6_rst_rdata", WS), HRDATA, 32'h0);
      @(negedge HCLK);
      rstn = 1'b1; dp_active = 1'b0;
      issue(2'b10, 1'b0, 3'd2, 32'h40, 32'h0, 1'b0);
      flush();
      chk($sformatf("ws%0d_t6_kept", WS), last_rdata, 32'h1234_5678);

      for (int n = 0; n < 300; n++) begin
        k  = $urandom_range(9);
        sz = (k < 3) ? 3'd0 : (k < 6) ? 3'd1 : (k < 9) ? 3'd2 : 3'($urandom_range(3, 7));
        off = 32'($urandom_range(1023));
        if ($urandom_range(7) != 0 && sz <= 3'd2) off = off & ~((32'd1 << sz) - 32'd1);
        if ($urandom_range(15) == 0) off = off + 32'd1024;
        addr = off;
        if ($urandom_range(3) == 0) addr = off | {16'($urandom), 16'h0};
        if ($urandom_range(9) != 0 && $urandom_range(3) != 0)
          issue(2'($urandom_range(2, 3)), 1'($urandom), sz, addr, $urandom, 1'b1);
        else
          step(1'($urandom), 2'($urandom), 1'($urandom), sz, addr, $urandom,
               $urandom_range(3) == 0, t);
      end
      flush();
      env_done[g] = 1'b1;
    end
  end

  initial begin : p_summary
    for (int c = 0; c < 90000 && !(env_done[0] && env_done[1]); c++) @(posedge HCLK);
    if (!(env_done[0] && env_done[1])) begin
      n_cmp++;
      n_fail++;
      $display("FAIL run_timeout: done=%0b%0b required 11", env_done[1], env_done[0]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
